// File: rtl/mem_line_arbiter_if.sv
// mem_line_arbiter_if: burst memory port shared by both cache miss paths.
interface mem_line_arbiter_if #(
    parameter int BURST_W = 64
);
    logic [31:0]        addr;
    logic               read;
    logic               write;
    logic [BURST_W-1:0] wdata;
    logic               ready;
    logic [31:0]        raddr;
    logic [BURST_W-1:0] rdata;
    logic               rvalid;

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid
    );

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: round-robin icache/dcache access to one burst memory port,
// assembling read lines from beats and serialising dcache write-backs into beats.
module mem_line_arbiter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          ic_addr,
    input  logic                 ic_read,
    output logic [LINE_W-1:0]    ic_rdata,
    output logic                 ic_resp,
    input  logic [31:0]          dc_addr,
    input  logic                 dc_read,
    input  logic                 dc_write,
    input  logic [LINE_W-1:0]    dc_wdata,
    output logic [LINE_W-1:0]    dc_rdata,
    output logic                 dc_resp,
    mem_line_arbiter_if.master   bmem
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [31:0] ALIGN = ~(32'(LINE_W / 8) - 32'd1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       addr_q, addr_d;
    logic              dc_gnt_q, dc_gnt_d;
    logic              wr_q, wr_d;
    logic              last_dc_q, last_dc_d;
    logic              dc_req, pick_dc, rd_on, wr_on, resp_on;

    assign dc_req  = dc_read || dc_write;
    // On a tie the requester that did not win last time goes first.
    assign pick_dc = dc_req && (!ic_read || !last_dc_q);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        line_d    = line_q;
        addr_d    = addr_q;
        dc_gnt_d  = dc_gnt_q;
        wr_d      = wr_q;
        last_dc_d = last_dc_q;
        case (state_q)
            IDLE: if (ic_read || dc_req) begin
                dc_gnt_d = pick_dc;
                wr_d     = pick_dc && dc_write;
                addr_d   = (pick_dc ? dc_addr : ic_addr) & ALIGN;
                beat_d   = '0;
                state_d  = (pick_dc && dc_write) ? WR_DATA : RD_CMD;
            end
            RD_CMD: if (bmem.ready) begin
                beat_d  = '0;
                state_d = RD_DATA;
            end
            RD_DATA: if (bmem.rvalid && bmem.raddr == addr_q) begin
                line_d[beat_q*BURST_W +: BURST_W] = bmem.rdata;
                beat_d  = beat_q + BW'(1);
                state_d = (beat_q == LAST) ? RESP : RD_DATA;
            end
            WR_DATA: if (bmem.ready) begin
                beat_d  = beat_q + BW'(1);
                state_d = (beat_q == LAST) ? RESP : WR_DATA;
            end
            RESP: begin
                last_dc_d = dc_gnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            dc_gnt_q  <= 1'b0;
            wr_q      <= 1'b0;
            last_dc_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            dc_gnt_q  <= dc_gnt_d;
            wr_q      <= wr_d;
            last_dc_q <= last_dc_d;
        end
    end

    assign rd_on      = state_q == RD_CMD;
    assign wr_on      = state_q == WR_DATA;
    assign resp_on    = state_q == RESP;
    assign bmem.read  = rd_on;
    assign bmem.write = wr_on;
    assign bmem.addr  = (rd_on || wr_on) ? addr_q : '0;
    assign bmem.wdata = wr_on ? dc_wdata[beat_q*BURST_W +: BURST_W] : '0;
    assign ic_resp    = resp_on && !dc_gnt_q;
    assign dc_resp    = resp_on && dc_gnt_q;
    assign ic_rdata   = ic_resp ? line_q : '0;
    assign dc_rdata   = (dc_resp && !wr_q) ? line_q : '0;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed vectors with hand-computed expectations for
// reads, write-backs, arbitration, dropped beats and mid-burst reset.
module tb_mem_line_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  ic_addr, dc_addr;
    logic         ic_read, dc_read, dc_write, ic_resp, dc_resp;
    logic [255:0] dc_wdata, ic_rdata, dc_rdata;

    mem_line_arbiter_if #(.BURST_W(64)) bmem ();

    mem_line_arbiter #(.LINE_W(256), .BURST_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ic_addr  (ic_addr),
        .ic_read  (ic_read),
        .ic_rdata (ic_rdata),
        .ic_resp  (ic_resp),
        .dc_addr  (dc_addr),
        .dc_read  (dc_read),
        .dc_write (dc_write),
        .dc_wdata (dc_wdata),
        .dc_rdata (dc_rdata),
        .dc_resp  (dc_resp),
        .bmem     (bmem.master)
    );

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'haaaa_0000_0000_000a;
    localparam logic [63:0] WB = 64'hbbbb_0000_0000_000b;
    localparam logic [63:0] WC = 64'hcccc_0000_0000_000c;
    localparam logic [63:0] WD = 64'hdddd_0000_0000_000d;
    localparam logic [63:0] JUNK = 64'hdead_beef_dead_beef;

    int passed = 0;
    int total = 0;
    int cmds = 0;
    int ic_resps = 0;
    int dc_resps = 0;
    int c0, i0, d0;

    always @(posedge clk) begin
        if (bmem.read && bmem.ready) cmds++;
        if (ic_resp) ic_resps++;
        if (dc_resp) dc_resps++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d);
        bmem.rvalid = 1'b1;
        bmem.raddr  = a;
        bmem.rdata  = d;
        cyc(1);
        bmem.rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        ic_addr = '0; dc_addr = '0; ic_read = 0; dc_read = 0; dc_write = 0; dc_wdata = '0;
        bmem.ready = 0; bmem.raddr = '0; bmem.rdata = '0; bmem.rvalid = 0;
        cyc(2);
        check("rst_read", 256'(bmem.read), 256'(0));
        check("rst_write", 256'(bmem.write), 256'(0));
        check("rst_addr", 256'(bmem.addr), 256'(0));
        check("rst_ic_resp", 256'(ic_resp), 256'(0));
        check("rst_ic_rdata", ic_rdata, 256'(0));
        rst_n = 1'b1;
        cyc(1);

        // icache read, minimum latency
        c0 = cmds;
        ic_addr = 32'h1eceb004; ic_read = 1; bmem.ready = 1;
        cyc(1);
        check("rd_cmd", 256'(bmem.read), 256'(1));
        check("rd_addr", 256'(bmem.addr), 256'(32'h1eceb000));
        cyc(1);
        check("rd_cmd_done", 256'(bmem.read), 256'(0));
        beat(32'h1eceb000, B1);
        beat(32'h1eceb000, B2);
        beat(32'h1eceb000, B3);
        check("rd_early_resp", 256'(ic_resp), 256'(0));
        beat(32'h1eceb000, B4);
        check("rd_resp", 256'(ic_resp), 256'(1));
        check("rd_line", ic_rdata, {B4, B3, B2, B1});
        check("rd_no_dc_resp", 256'(dc_resp), 256'(0));
        ic_read = 0;
        cyc(1);
        check("rd_resp_pulse", 256'(ic_resp), 256'(0));
        check("rd_rdata_zero", ic_rdata, 256'(0));
        check("rd_one_cmd", 256'(cmds - c0), 256'(1));

        // dcache write-back with a stalled first beat
        dc_addr = 32'h1000; dc_wdata = {WD, WC, WB, WA}; dc_write = 1; bmem.ready = 1;
        cyc(1);
        bmem.ready = 0;
        check("wr_write", 256'(bmem.write), 256'(1));
        check("wr_noread", 256'(bmem.read), 256'(0));
        check("wr_addr", 256'(bmem.addr), 256'(32'h1000));
        check("wr_beat_a0", 256'(bmem.wdata), 256'(WA));
        cyc(1);
        bmem.ready = 1;
        check("wr_beat_a1", 256'(bmem.wdata), 256'(WA));
        cyc(1);
        check("wr_beat_b", 256'(bmem.wdata), 256'(WB));
        cyc(1);
        check("wr_beat_c", 256'(bmem.wdata), 256'(WC));
        cyc(1);
        check("wr_beat_d", 256'(bmem.wdata), 256'(WD));
        check("wr_no_resp_yet", 256'(dc_resp), 256'(0));
        cyc(1);
        check("wr_resp", 256'(dc_resp), 256'(1));
        check("wr_write_off", 256'(bmem.write), 256'(0));
        dc_write = 0;
        cyc(1);
        check("wr_resp_pulse", 256'(dc_resp), 256'(0));

        // simultaneous requests after reset: icache first, then dcache
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        cyc(1);
        c0 = cmds; i0 = ic_resps; d0 = dc_resps;
        ic_addr = 32'h3000; dc_addr = 32'h1008; ic_read = 1; dc_read = 1; bmem.ready = 1;
        cyc(1);
        check("arb_first_addr", 256'(bmem.addr), 256'(32'h3000));
        cyc(1);
        beat(32'h3000, B4);
        beat(32'h3000, B3);
        beat(32'h3000, B2);
        beat(32'h3000, B1);
        check("arb_ic_resp", 256'(ic_resp), 256'(1));
        check("arb_dc_wait", 256'(dc_resp), 256'(0));
        check("arb_ic_line", ic_rdata, {B1, B2, B3, B4});
        check("arb_no_cmd_in_resp", 256'(bmem.read), 256'(0));
        ic_read = 0;
        cyc(2);
        check("arb_second_cmd", 256'(bmem.read), 256'(1));
        check("arb_second_addr", 256'(bmem.addr), 256'(32'h1000));
        cyc(1);

        // non-matching beat is dropped
        beat(32'h1000, B1);
        beat(32'h2000, JUNK);
        beat(32'h1000, B2);
        beat(32'h1000, B3);
        check("drop_no_resp", 256'(dc_resp), 256'(0));
        beat(32'h1000, B4);
        check("drop_resp", 256'(dc_resp), 256'(1));
        check("drop_line", dc_rdata, {B4, B3, B2, B1});
        dc_read = 0;
        cyc(1);
        check("arb_cmds", 256'(cmds - c0), 256'(2));
        check("arb_ic_count", 256'(ic_resps - i0), 256'(1));
        check("arb_dc_count", 256'(dc_resps - d0), 256'(1));

        // reset mid-burst, late beats ignored, fresh read works
        i0 = ic_resps;
        ic_addr = 32'h5000; ic_read = 1;
        cyc(2);
        beat(32'h5000, B1);
        beat(32'h5000, B2);
        rst_n = 0; ic_read = 0;
        #1;
        check("abort_read", 256'(bmem.read), 256'(0));
        check("abort_ic_resp", 256'(ic_resp), 256'(0));
        check("abort_rdata", ic_rdata, 256'(0));
        cyc(1);
        rst_n = 1;
        beat(32'h5000, B3);
        beat(32'h5000, B4);
        cyc(3);
        check("abort_no_resp", 256'(ic_resps - i0), 256'(0));
        ic_addr = 32'h6000; ic_read = 1;
        cyc(2);
        beat(32'h6000, WA);
        beat(32'h6000, WB);
        beat(32'h6000, WC);
        beat(32'h6000, WD);
        check("fresh_resp", 256'(ic_resp), 256'(1));
        check("fresh_line", ic_rdata, {WD, WC, WB, WA});
        ic_read = 0;
        cyc(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single burst memory port (bmem) between the instruction-cache and data-cache miss paths.
- Arbitrates between the two caches round-robin.
- Read misses: collects four 64-bit beats into one 256-bit line.
- Dirty write-backs: serialises a 256-bit line into four 64-bit beats.
- Sits between both caches and the top-level memory interface; the fetch stage sees it only as added icache miss latency.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W = 4.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_addr  in  32  icache line-miss address.
- ic_read  in  1  icache line-read request, level, held until ic_resp.
- ic_rdata  out  LINE_W  fill line, valid only while ic_resp=1.
- ic_resp  out  1  one-cycle completion pulse.
- dc_addr  in  32  dcache line address.
- dc_read  in  1  dcache line-read request, level.
- dc_write  in  1  dcache write-back request, level.
- dc_wdata  in  LINE_W  write-back line, stable while dc_write=1.
- dc_rdata  out  LINE_W  fill line, valid while dc_resp=1.
- dc_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  line-aligned memory address, bits [4:0] = 0.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BURST_W  write beat data.
- bmem_ready  in  1  memory accepts a command or write beat this cycle.
- bmem_raddr  in  32  address tag of the returning read beat.
- bmem_rdata  in  BURST_W  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Enter IDLE; clear beat counter and line buffer; last_grant = DC.
  - All outputs 0.
  - Reset mid-burst aborts the transaction; no resp is issued afterwards.
  - Late bmem_rvalid beats after reset are ignored.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE arbitration, evaluated each cycle:
  - One requester pending: grant it.
  - Both pending: grant the requester that was not last_grant.
  - Latch the granted address with [4:0] forced to 0, the granted id, and the op.
  - dc_read and dc_write both high: treated as a write.
  - Transitions: read → RD_CMD; write → WR_DATA with beat=0.
- RD_CMD:
  - bmem_read=1 and bmem_addr held until the cycle bmem_ready=1; that cycle is the command handshake.
  - Next state RD_DATA, beat=0.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 and bmem_raddr == latched address writes bmem_rdata into line slice [beat*64 +: 64] (beat 0 = bits 63:0), then beat++.
  - Beats with a non-matching raddr are dropped.
  - On the 4th accepted beat → RESP.
- WR_DATA:
  - bmem_write=1, bmem_addr = latched address, bmem_wdata = dc_wdata[beat*64 +: 64].
  - Beat advances only in cycles where bmem_ready=1.
  - After beat 3 is accepted → RESP.
  - bmem_read is never asserted in this state.
- RESP:
  - Exactly one cycle; assert the granted requester's resp.
  - Read: drive rdata = line buffer. Write: dc_rdata is don't-care.
  - Update last_grant to the granted id; → IDLE.
  - Requests are not sampled in RESP; requesters must deassert or change their request by the cycle after resp.
- Latency: minimum read = 1 (grant) + 1 (cmd) + 4 beats + 1 (resp) = 7 cycles.
- Outputs outside their states:
  - bmem_read=0, bmem_write=0.
  - resp=0.
  - rdata outputs are 0 when their resp is 0.
- Stray bmem_rvalid in IDLE, RD_CMD, WR_DATA or RESP: ignored.
- No memory command is issued without a grant; at most one transaction is outstanding.

Test Plan:
- Reset, then ic_read=1, ic_addr=0x1eceb004, bmem_ready=1, four beats 0x11..,0x22..,0x33..,0x44.. → bmem_addr=0x1eceb000 with one bmem_read pulse; ic_resp pulses at cycle 7; ic_rdata={0x44..,0x33..,0x22..,0x11..}.
- dc_write=1, dc_addr=0x1000, dc_wdata=beats A,B,C,D; bmem_ready toggles 1,0,1,1,1 → bmem_wdata sequence A,A,B,C,D, with the beat advancing only on ready cycles; one dc_resp pulse after D is accepted.
- ic_read and dc_read raised in the same cycle after reset → dcache is serviced second (last_grant=DC after reset, so icache wins first), then dcache; no overlapping bmem_read commands.
- RD_DATA with a beat whose raddr=0x2000 while the latched address is 0x1000 → beat dropped; line completes only after 4 matching beats.
- rst_n pulled low after 2 read beats → all outputs 0 immediately; the remaining 2 beats arrive with no resp; a fresh ic_read then completes normally.
